// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and parameter-legality helpers for the UART TX
//               with transmit FIFO.
// Revision    : 1.0
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        ODD  = 2'd1,
        EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } tx_state_e;

    localparam int c_MIN_WAIT_DIV   = 2;
    localparam int c_MIN_DATA_BITS  = 5;
    localparam int c_MAX_DATA_BITS  = 9;
    localparam int c_MAX_STOP_BITS  = 2;
    localparam int c_MIN_FIFO_DEPTH = 2;

    function automatic bit cfg_ok(input int wait_div, input int data_bits,
                                  input int parity, input int stop_bits,
                                  input int fifo_depth);
        return (wait_div >= c_MIN_WAIT_DIV)
            && (data_bits >= c_MIN_DATA_BITS) && (data_bits <= c_MAX_DATA_BITS)
            && (parity >= int'(NONE)) && (parity <= int'(EVEN))
            && (stop_bits >= 1) && (stop_bits <= c_MAX_STOP_BITS)
            && (fifo_depth >= c_MIN_FIFO_DEPTH)
            && ((fifo_depth & (fifo_depth - 1)) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_sync_fifo
// Description : Single-clock FIFO with registered full flag; a push is only
//               accepted while the registered full flag is low.
// Revision    : 1.0
// ============================================================================
module uart_sync_fifo #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 4,
    localparam int c_AW  = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             push_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [c_AW:0]    count_o
);

    localparam logic [c_AW:0] c_FULL_CNT = (c_AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [c_AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [c_AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [c_AW:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign w_push_ok = push_i && !full_q;
    assign w_pop_ok  = pop_i && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({w_push_ok, w_pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        full_d = (count_d == c_FULL_CNT);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
        end
    end

    // Storage needs no reset: contents are only read once the count says so.
    always_ff @(posedge clk_i) begin
        if (w_push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Parametrised serial transmitter with a TX FIFO; sends queued
//               characters back-to-back on a flop-driven serial line.
// Revision    : 1.0
// ============================================================================
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int WAIT_DIV   = 5,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [DATA_BITS-1:0] DATA_IN,
    input  logic                 WE,
    output logic                 FULL,
    output logic                 OVERFLOW,
    output logic                 DATA_OUT,
    output logic                 BUSY
);

    localparam int c_DIV_W = $clog2(WAIT_DIV);
    localparam int c_BIT_W = $clog2(DATA_BITS + 1);
    localparam int c_CNT_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [c_DIV_W-1:0] c_DIV_LAST  = c_DIV_W'(WAIT_DIV - 1);
    localparam logic [c_BIT_W-1:0] c_DATA_LAST = c_BIT_W'(DATA_BITS - 1);
    localparam logic [c_BIT_W-1:0] c_STOP_LAST = c_BIT_W'(STOP_BITS - 1);
    localparam bit                 c_HAS_PAR   = (PARITY != int'(NONE));
    localparam bit                 c_ODD_PAR   = (PARITY == int'(ODD));

    if (!cfg_ok(WAIT_DIV, DATA_BITS, PARITY, STOP_BITS, FIFO_DEPTH)) begin : g_cfg_check
        $error("uart_tx_fifo: illegal parameter combination");
    end

    tx_state_e            state_q, state_d;
    logic [c_DIV_W-1:0]   div_q, div_d;
    logic [c_BIT_W-1:0]   bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 dout_q, dout_d;
    logic                 ovf_q;

    logic                 w_pop;
    logic                 w_div_end;
    logic [DATA_BITS-1:0] w_head;
    logic                 w_full;
    logic                 w_empty;
    logic [c_CNT_W-1:0]   w_count;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_i   (RST),
        .data_i  (DATA_IN),
        .push_i  (WE),
        .pop_i   (w_pop),
        .data_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (w_count)
    );

    assign w_div_end = (div_q == c_DIV_LAST);

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        w_pop   = 1'b0;

        if (state_q != IDLE) begin
            div_d = w_div_end ? '0 : div_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (!w_empty) begin
                    w_pop   = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (w_div_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (w_div_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == c_DATA_LAST) begin
                        bit_d   = '0;
                        state_d = c_HAS_PAR ? PAR : STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            PAR: begin
                if (w_div_end) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (w_div_end) begin
                    if (bit_q == c_STOP_LAST) begin
                        bit_d = '0;
                        // Chain straight into the next frame when data is waiting.
                        if (!w_empty) begin
                            w_pop   = 1'b1;
                            state_d = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (w_pop) begin
            shift_d = w_head;
            par_d   = (^w_head) ^ c_ODD_PAR;
        end
    end

    // Line level is registered from the state so DATA_OUT has no path from WE.
    always_comb begin
        dout_d = 1'b1;
        case (state_q)
            START:   dout_d = 1'b0;
            DATA:    dout_d = shift_q[0];
            PAR:     dout_d = par_q;
            default: dout_d = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            dout_q  <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            dout_q  <= dout_d;
            ovf_q   <= WE && w_full;
        end
    end

    assign FULL     = w_full;
    assign OVERFLOW = ovf_q;
    assign DATA_OUT = dout_q;
    assign BUSY     = (w_count != '0) || (state_q != IDLE);

endmodule
`default_nettype wire
